seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle successor to the square-root datapath's combinational 17-bit A<B comparator.
- Compares two WIDTH-bit operands digit-serially, MSB digit first, DIGIT bits per cycle.
- Selectable unsigned/signed (two's complement) mode; full lt/eq/gt result.
- Terminates early on the first differing digit; start/ready/done handshake lets the square-root controller trade area for latency.

---
 rtl/seq_magnitude_comparator_if.sv | 32 +++
 rtl/seq_magnitude_comparator.sv | 119 +++++++++++
 tb/tb_seq_magnitude_comparator.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// +----------------------------------------------------------------------------+
// | Module  : seq_magnitude_comparator_if                                      |
// | Brief   : start/ready/done request and result bundle for the comparator    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 17
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             ready_o;
  logic             done_o;
  logic             A_less_than_B_o;
  logic             A_equal_B_o;
  logic             A_greater_than_B_o;

  modport master (
    output start_i, signed_i, A_i, B_i,
    input  ready_o, done_o, A_less_than_B_o, A_equal_B_o, A_greater_than_B_o
  );

  modport slave (
    input  start_i, signed_i, A_i, B_i,
    output ready_o, done_o, A_less_than_B_o, A_equal_B_o, A_greater_than_B_o
  );
endinterface

`default_nettype wire

// File: rtl/seq_magnitude_comparator.sv
// +----------------------------------------------------------------------------+
// | Module  : seq_magnitude_comparator                                         |
// | Brief   : digit-serial MSB-first lt/eq/gt comparator, unsigned or signed   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_magnitude_comparator #(
  parameter int WIDTH = 17,
  parameter int DIGIT = 4
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_n_i,
  seq_magnitude_comparator_if.slave  bus
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int EXTW = NDIG * DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [EXTW-1:0] MSB_MASK = {1'b1, {(EXTW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [EXTW-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic [EXTW-1:0] a_raw, b_raw, a_ext, b_ext;
  logic [DIGIT-1:0] a_top, b_top;

  // Padding bits fill the top digit; they carry the sign only in signed mode.
  if (EXTW > WIDTH) begin : g_pad
    assign a_raw = {{(EXTW-WIDTH){bus.signed_i & bus.A_i[WIDTH-1]}}, bus.A_i};
    assign b_raw = {{(EXTW-WIDTH){bus.signed_i & bus.B_i[WIDTH-1]}}, bus.B_i};
  end else begin : g_nopad
    assign a_raw = bus.A_i;
    assign b_raw = bus.B_i;
  end

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign a_ext = bus.signed_i ? (a_raw ^ MSB_MASK) : a_raw;
  assign b_ext = bus.signed_i ? (b_raw ^ MSB_MASK) : b_raw;

  assign a_top = a_q[EXTW-1 -: DIGIT];
  assign b_top = b_q[EXTW-1 -: DIGIT];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_d     = a_ext;
          b_d     = b_ext;
          cnt_d   = CW'(NDIG);
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (a_top != b_top) begin
          lt_d    = (a_top < b_top);
          gt_d    = (a_top > b_top);
          state_d = S_DONE;
        end else if (cnt_q == CW'(1)) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          a_d   = a_q << DIGIT;
          b_d   = b_q << DIGIT;
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready_o            = (state_q == S_IDLE);
  assign bus.done_o             = (state_q == S_DONE);
  assign bus.A_less_than_B_o    = lt_q;
  assign bus.A_equal_B_o        = eq_q;
  assign bus.A_greater_than_B_o = gt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_magnitude_comparator                                      |
// | Brief   : vector table plus handshake/reset sequences, queue scoreboard    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_magnitude_comparator;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  seq_magnitude_comparator_if #(.WIDTH(17)) bus0 ();
  seq_magnitude_comparator_if #(.WIDTH(8))  bus1 ();

  seq_magnitude_comparator #(.WIDTH(17), .DIGIT(4)) dut0 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus0.slave)
  );

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus1.slave)
  );

  typedef struct {
    bit          sel;   // 0: 17/4 instance, 1: 8/8 instance
    bit          sgn;
    logic [16:0] a;
    logic [16:0] b;
    logic [2:0]  exp;   // {lt, eq, gt}
    int          k;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    int         k;
  } sb_t;

  int   tests = 0;
  int   fails = 0;
  sb_t  sb_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input bit sgn,
                       input logic [16:0] a, input logic [16:0] b);
    if (sel) begin
      bus1.start_i = st; bus1.signed_i = sgn; bus1.A_i = a[7:0]; bus1.B_i = b[7:0];
    end else begin
      bus0.start_i = st; bus0.signed_i = sgn; bus0.A_i = a; bus0.B_i = b;
    end
  endtask

  task automatic sample(input bit sel, output logic rdy, output logic dn, output logic [2:0] res);
    if (sel) begin
      rdy = bus1.ready_o; dn = bus1.done_o;
      res = {bus1.A_less_than_B_o, bus1.A_equal_B_o, bus1.A_greater_than_B_o};
    end else begin
      rdy = bus0.ready_o; dn = bus0.done_o;
      res = {bus0.A_less_than_B_o, bus0.A_equal_B_o, bus0.A_greater_than_B_o};
    end
  endtask

  // Waits for done_o (bounded), pops the scoreboard and checks result and latency.
  task automatic wait_done(input bit sel, input string name, input int edges_so_far);
    logic rdy, dn;
    logic [2:0] res;
    int cycles;
    sb_t e;
    cycles = edges_so_far;
    sample(sel, rdy, dn, res);
    while (!dn && cycles < 40) begin
      @(posedge clk_i); #1;
      cycles++;
      sample(sel, rdy, dn, res);
    end
    e = sb_q.pop_front();
    if (!dn) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no done_o expected done_o", name);
    end else begin
      check({name, "_res"}, 32'(res), 32'(e.res));
      check({name, "_k"}, 32'(cycles), 32'(e.k));
    end
    @(posedge clk_i); #1;
    sample(sel, rdy, dn, res);
    check({name, "_ready_after"}, {30'd0, rdy, dn}, 32'b10);
  endtask

  // Caller is #1 after a rising edge with the target instance idle.
  task automatic run_op(input bit sel, input bit sgn, input logic [16:0] a, input logic [16:0] b,
                        input logic [2:0] exp, input int k, input string name);
    logic rdy, dn;
    logic [2:0] res;
    sb_t e;
    drive(sel, 1'b1, sgn, a, b);
    e.res = exp; e.k = k;
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    drive(sel, 1'b0, ~sgn, ~a, b);
    sample(sel, rdy, dn, res);
    check({name, "_accept"}, {28'd0, rdy, dn, res[1:0]} | {29'd0, res[2], 2'd0}, 32'd0);
    wait_done(sel, name, 0);
  endtask

  initial begin
    logic rdy, dn;
    logic [2:0] res;
    int extra;

    vecs[0]  = '{0, 0, 17'h14001, 17'h1A001, 3'b100, 2};
    vecs[1]  = '{0, 1, 17'h14001, 17'h1A001, 3'b100, 2};
    vecs[2]  = '{0, 0, 17'h00001, 17'h10000, 3'b100, 1};
    vecs[3]  = '{0, 1, 17'h00001, 17'h10000, 3'b001, 1};
    vecs[4]  = '{0, 0, 17'h0ABCD, 17'h0ABCD, 3'b010, 5};
    vecs[5]  = '{0, 0, 17'h00002, 17'h00001, 3'b001, 5};
    vecs[6]  = '{0, 1, 17'h1FFFF, 17'h1FFFF, 3'b010, 5};
    vecs[7]  = '{0, 1, 17'h1FFFF, 17'h00000, 3'b100, 1};
    vecs[8]  = '{0, 0, 17'h1FFFF, 17'h00000, 3'b001, 1};
    vecs[9]  = '{1, 0, 17'h00080, 17'h0007F, 3'b001, 1};
    vecs[10] = '{1, 1, 17'h00080, 17'h0007F, 3'b100, 1};
    vecs[11] = '{1, 1, 17'h00005, 17'h00005, 3'b010, 1};

    drive(0, 1'b0, 0, 17'h0, 17'h0);
    drive(1, 1'b0, 0, 17'h0, 17'h0);
    repeat (2) @(posedge clk_i);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], rdy, dn, res);
      check($sformatf("reset_state%0d", s), {27'd0, rdy, dn, res}, {27'd0, 1'b1, 1'b0, 3'b000});
    end
    @(negedge clk_i); rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].sel, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].k,
             $sformatf("vec%0d", i));

    // Results held through idle, cleared by next accept.
    run_op(0, 0, 17'h0ABCD, 17'h0ABCD, 3'b010, 5, "hold_op");
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk_i); #1; end
      sample(0, rdy, dn, res);
      check($sformatf("hold%0d", c), {29'd0, res}, 32'b010);
    end
    @(posedge clk_i); #1;
    run_op(0, 0, 17'h00003, 17'h00004, 3'b100, 5, "after_hold");

    // start_i pulsed while busy must be ignored.
    drive(0, 1'b1, 0, 17'h0ABCD, 17'h0ABCD);
    begin sb_t e; e.res = 3'b010; e.k = 5; sb_q.push_back(e); end
    @(posedge clk_i); #1;
    drive(0, 1'b0, 0, 17'h0, 17'h0);
    @(posedge clk_i); #1;
    drive(0, 1'b1, 0, 17'h00001, 17'h00000);
    @(posedge clk_i); #1;
    drive(0, 1'b0, 0, 17'h0, 17'h0);
    wait_done(0, "busy_ign", 2);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      sample(0, rdy, dn, res);
      if (dn || !rdy) extra++;
    end
    check("busy_single_done", 32'(extra), 32'd0);

    // Reset asserted mid-compare aborts asynchronously with no done_o.
    drive(0, 1'b1, 0, 17'h0ABCD, 17'h0ABCD);
    @(posedge clk_i); #1;
    drive(0, 1'b0, 0, 17'h0, 17'h0);
    @(posedge clk_i); #2;
    rst_n_i = 1'b0;
    #1;
    sample(0, rdy, dn, res);
    check("rst_async", {27'd0, rdy, dn, res}, {27'd0, 1'b1, 1'b0, 3'b000});
    extra = 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      sample(0, rdy, dn, res);
      if (dn) extra++;
    end
    @(negedge clk_i); rst_n_i = 1'b1;
    repeat (6) begin
      @(posedge clk_i); #1;
      sample(0, rdy, dn, res);
      if (dn) extra++;
    end
    check("rst_no_done", 32'(extra), 32'd0);
    run_op(0, 1, 17'h10000, 17'h00001, 3'b100, 1, "post_rst");

    // Reset in idle clears held results.
    #2 rst_n_i = 1'b0;
    #1;
    sample(0, rdy, dn, res);
    check("rst_idle_clr", {29'd0, res}, 32'd0);
    @(negedge clk_i); rst_n_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
